// File: rtl/ch5_pkg.sv
// ch5_pkg: direction encodings and Gray helper shared by the chapter-5 counters
package ch5_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/mod_step_counter_if.sv
// mod_step_counter_if: control and status bundle of the modulo step counter
interface mod_step_counter_if #(parameter int WIDTH = 2, parameter int SHIFT = 1);
  logic en;
  logic dir;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH+SHIFT-1:0] out;
  logic [WIDTH-1:0] gray;
  logic tc;
  logic wrap;
  modport master(output en, dir, load, load_val, input out, gray, tc, wrap);
  modport slave(input en, dir, load, load_val, output out, gray, tc, wrap);
endinterface

// File: rtl/dff_en_srst.sv
// dff_en_srst: W-bit register with enable and synchronous active-low clear
module dff_en_srst #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mod_step_counter.sv
// mod_step_counter: modulo-MOD up/down counter with load, terminal count, wrap pulse and Gray output
module mod_step_counter import ch5_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int MOD   = 2**WIDTH,
  parameter int SHIFT = 1
) (
  input logic clk,
  input logic rst,
  mod_step_counter_if.slave bus
);
  if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
    $error("mod_step_counter: MOD out of range");
  end
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  logic [WIDTH-1:0] count, count_nxt;
  logic wrap_nxt, at_max, at_zero;
  assign at_max  = count == MAXV;
  assign at_zero = count == '0;
  always_comb begin
    count_nxt = bus.load ? ((bus.load_val > MAXV) ? MAXV : bus.load_val) :
                (bus.dir == DIR_UP) ? (at_max ? '0 : count + WIDTH'(1)) :
                (at_zero ? MAXV : count - WIDTH'(1));
    wrap_nxt  = !bus.load && bus.en && ((bus.dir == DIR_UP) ? at_max : at_zero);
  end
  dff_en_srst #(.W(WIDTH)) u_count (
    .clk(clk), .rst(rst), .en(bus.load | bus.en), .d(count_nxt), .q(count)
  );
  dff_en_srst #(.W(1)) u_wrap (
    .clk(clk), .rst(rst), .en(1'b1), .d(wrap_nxt), .q(bus.wrap)
  );
  assign bus.out  = {count, {SHIFT{1'b0}}};
  assign bus.gray = WIDTH'(bin2gray(32'(count)));
  assign bus.tc   = (bus.dir == DIR_UP) ? at_max : at_zero;
endmodule

// File: tb/tb_mod_step_counter.sv
// tb_mod_step_counter: directed checks of the default 4-state counter and a MOD=5 variant
module tb_mod_step_counter;
  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mod_step_counter_if #(.WIDTH(2), .SHIFT(1)) ifa ();
  mod_step_counter_if #(.WIDTH(3), .SHIFT(1)) ifb ();
  mod_step_counter #(.WIDTH(2), .MOD(4), .SHIFT(1)) ua (.clk(clk), .rst(rst), .bus(ifa));
  mod_step_counter #(.WIDTH(3), .MOD(5), .SHIFT(1)) ub (.clk(clk), .rst(rst), .bus(ifb));
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chka(input string tag, input int out, input int gray, input int tc, input int wrap);
    chk({tag, ".out"}, int'(ifa.out), out);
    chk({tag, ".gray"}, int'(ifa.gray), gray);
    chk({tag, ".tc"}, int'(ifa.tc), tc);
    chk({tag, ".wrap"}, int'(ifa.wrap), wrap);
  endtask
  task automatic chkb(input string tag, input int out, input int tc, input int wrap);
    chk({tag, ".out"}, int'(ifb.out), out);
    chk({tag, ".tc"}, int'(ifb.tc), tc);
    chk({tag, ".wrap"}, int'(ifb.wrap), wrap);
  endtask
  initial begin
    ifa.en = 1; ifa.dir = 0; ifa.load = 1; ifa.load_val = 2;
    ifb.en = 1; ifb.dir = 1; ifb.load = 0; ifb.load_val = 0;
    step();
    chka("reset", 0, 0, 1, 0);
    chkb("reset_b", 0, 0, 0);
    rst = 1; ifa.load = 0; ifa.dir = 1; ifb.en = 0;
    step(); chka("up1", 2, 1, 0, 0);
    step(); chka("up2", 4, 3, 0, 0);
    step(); chka("up3", 6, 2, 1, 0);
    step(); chka("up_wrap", 0, 0, 0, 1);
    ifa.en = 0;
    step(); chka("hold0", 0, 0, 0, 0);
    ifa.dir = 0; #1;
    chk("tc_dn_at0", int'(ifa.tc), 1);
    ifa.en = 1;
    step(); chka("dn_wrap", 6, 2, 0, 1);
    step(); chka("dn2", 4, 3, 0, 0);
    step(); chka("dn1", 2, 1, 0, 0);
    step(); chka("dn0", 0, 0, 1, 0);
    ifa.en = 0; ifa.load = 1; ifa.load_val = 1;
    step(); chka("load1", 2, 1, 0, 0);
    ifa.en = 1; ifa.dir = 1; ifa.load_val = 2;
    step(); chka("load_wins", 4, 3, 0, 0);
    ifa.en = 0; ifa.load = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chka("hold2", 4, 3, 0, 0);
    end
    ifa.load = 1; ifa.load_val = 3;
    step(); chka("load3", 6, 2, 1, 0);
    ifa.en = 1;
    step(); chka("load_at_max", 6, 2, 1, 0);
    ifa.load = 0;
    step(); chka("wrap_after_load", 0, 0, 0, 1);
    step(); chka("up_after", 2, 1, 0, 0);
    rst = 0; ifa.load = 1; ifa.load_val = 3;
    step(); chka("rst_wins", 0, 0, 0, 0);
    rst = 1; ifa.load = 0;
    step(); chka("post_rst", 2, 1, 0, 0);
    ifa.en = 0;
    #2 rst = 0;
    #2 rst = 1;
    step(); chka("rst_glitch", 2, 1, 0, 0);
    ifb.en = 1; ifb.dir = 1;
    step(); chkb("b_up1", 2, 0, 0);
    step(); chkb("b_up2", 4, 0, 0);
    step(); chkb("b_up3", 6, 0, 0);
    step(); chkb("b_up4", 8, 1, 0);
    step(); chkb("b_wrap", 0, 0, 1);
    step(); chkb("b_up1b", 2, 0, 0);
    ifb.load = 1; ifb.load_val = 7;
    step(); chkb("b_clamp", 8, 1, 0);
    ifb.load_val = 0;
    step(); chkb("b_load0", 0, 0, 0);
    ifb.load = 0; ifb.dir = 0;
    step(); chkb("b_dn_wrap", 8, 0, 1);
    step(); chkb("b_dn3", 6, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
